// File: rtl/usb_pkg.sv
// Shared PID codes, sequencer state encoding and PID helpers for the USB
// bus-ownership sequencer.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  typedef enum logic [1:0] {
    IDLE,
    TURN,
    TX,
    WAIT_HS
  } seq_state_e;

  function automatic logic is_data_pid(input logic [3:0] pid);
    return (pid == PID_DATA0) || (pid == PID_DATA1);
  endfunction

endpackage

// File: rtl/usb_timer.sv
// Saturating up-counter with synchronous clear and a terminal-count flag
// against a runtime limit; shared by turnaround and handshake timing.
module usb_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tc = (count_q == limit);

  // Holds at the limit rather than wrapping.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !tc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/usb_bus_sequencer.sv
// Half-duplex bus-ownership sequencer: decides the response to received
// packets, times the turnaround and handshake wait, and tracks DATA toggle.
module usb_bus_sequencer
  import usb_pkg::*;
#(
  parameter int TURN_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 144,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rx_active,
  input  logic       rx_eop,
  input  logic       rx_error,
  input  logic [3:0] rx_pid,
  input  logic       tx_data_ready,
  input  logic       tx_done,
  output logic [3:0] Encode_Instruction,
  output logic       tx_start,
  output logic       USBOE,
  output logic       data_toggle,
  output logic       timeout,
  output logic       busy
);

  localparam logic [CNT_W-1:0] TURN_LIM    = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [3:0]       resp_q, resp_d;
  logic [3:0]       enc_q, enc_d;
  logic             tx_start_q, tx_start_d;
  logic             usboe_q, usboe_d;
  logic             toggle_q, toggle_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;
  logic             rx_active_q;
  logic             timer_clr;
  logic             timer_en;
  logic [CNT_W-1:0] timer_limit;
  logic             timer_tc;

  usb_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (timer_clr),
    .en    (timer_en),
    .limit (timer_limit),
    .tc    (timer_tc)
  );

  always_comb begin
    state_d     = state_q;
    resp_d      = resp_q;
    enc_d       = enc_q;
    tx_start_d  = 1'b0;
    usboe_d     = usboe_q;
    toggle_d    = toggle_q;
    timeout_d   = 1'b0;
    timer_clr   = 1'b0;
    timer_en    = 1'b0;
    timer_limit = TURN_LIM;
    case (state_q)
      IDLE: begin
        timer_clr = 1'b1;
        if (rx_eop && !rx_error) begin
          if (rx_pid == PID_IN) begin
            resp_d  = tx_data_ready ? (toggle_q ? PID_DATA1 : PID_DATA0) : PID_NAK;
            state_d = TURN;
          end else if (is_data_pid(rx_pid)) begin
            resp_d  = PID_ACK;
            state_d = TURN;
          end else if (rx_pid == PID_SETUP) begin
            toggle_d = 1'b1;
          end
        end
      end
      TURN: begin
        timer_en = 1'b1;
        // Host started a new packet before we took the bus: back off.
        if (rx_active && !rx_active_q) begin
          state_d = IDLE;
        end else if (timer_tc) begin
          tx_start_d = 1'b1;
          usboe_d    = 1'b1;
          enc_d      = resp_q;
          state_d    = TX;
        end
      end
      TX: begin
        timer_clr = 1'b1;
        if (tx_done) begin
          usboe_d = 1'b0;
          state_d = is_data_pid(resp_q) ? WAIT_HS : IDLE;
        end
      end
      WAIT_HS: begin
        timer_en    = !rx_active;
        timer_limit = TIMEOUT_LIM;
        // A packet ending on the terminal cycle takes priority over timeout.
        if (rx_eop) begin
          if (!rx_error && rx_pid == PID_ACK) begin
            toggle_d = ~toggle_q;
          end
          state_d = IDLE;
        end else if (timer_tc) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      resp_q      <= 4'b0000;
      enc_q       <= 4'b0000;
      tx_start_q  <= 1'b0;
      usboe_q     <= 1'b0;
      toggle_q    <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      rx_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      resp_q      <= resp_d;
      enc_q       <= enc_d;
      tx_start_q  <= tx_start_d;
      usboe_q     <= usboe_d;
      toggle_q    <= toggle_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
      rx_active_q <= rx_active;
    end
  end

  assign Encode_Instruction = enc_q;
  assign tx_start           = tx_start_q;
  assign USBOE              = usboe_q;
  assign data_toggle        = toggle_q;
  assign timeout            = timeout_q;
  assign busy               = busy_q;

endmodule

// File: doc/usb_bus_sequencer.md
# usb_bus_sequencer

Half-duplex bus-ownership sequencer for the USB transceiver. It watches packets completed by the receive path and decides whether, when and what the transmit path sends back. It drives the transmitter's encode instruction and the bus output-enable, enforces the inter-packet turnaround delay and the handshake timeout, and tracks the DATA0/DATA1 toggle. It sits between the receiver/decoder outputs and the transmitter inputs, alongside the main RCU.

## Interface
Parameters:
- TURN_CYCLES, 16, clk cycles of bus idle between rx_eop and transmit start; must be ≥ 1
- TIMEOUT_CYCLES, 144, clk cycles to wait for host ACK after a DATA packet; must be > TURN_CYCLES and ≤ 2^CNT_W
- CNT_W, 8, width of the shared turnaround/timeout counter

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset, asynchronous, active-low
- rx_active  in  1  receiver is decoding a packet (SYNC seen, EOP not yet)
- rx_eop  in  1  one-cycle pulse at end of a received packet
- rx_error  in  1  CRC/bit-stuff/PID error on the packet ending with rx_eop; sampled only with rx_eop
- rx_pid  in  4  PID of that packet; sampled only with rx_eop
- tx_data_ready  in  1  endpoint buffer holds a complete data payload
- tx_done  in  1  one-cycle pulse: transmitter finished the packet including EOP
- Encode_Instruction  out  4  PID the transmitter must send
- tx_start  out  1  one-cycle pulse: start transmitting Encode_Instruction
- USBOE  out  1  transmitter owns the bus
- data_toggle  out  1  0 = next IN data uses DATA0, 1 = DATA1
- timeout  out  1  one-cycle pulse: no handshake within TIMEOUT_CYCLES
- busy  out  1  state ≠ IDLE

## Operation
- PIDs: OUT 0001, IN 1001, SETUP 1101, DATA0 0011, DATA1 1011, ACK 0010, NAK 1010.
- States are IDLE, TURN, TX and WAIT_HS.
- IDLE (USBOE=0), on rx_eop:
  - rx_error=1: ignore; stay IDLE.
  - IN: latch resp = tx_data_ready ? (data_toggle ? DATA1 : DATA0) : NAK; go to TURN with the counter cleared.
  - DATA0 or DATA1: latch resp = ACK; go to TURN.
  - SETUP: data_toggle ← 1; stay IDLE.
  - Any other PID: stay IDLE.
- TURN:
  - The counter increments each cycle.
  - If rx_active rises, the host is talking: abort to IDLE with no transmit.
  - When count = TURN_CYCLES−1: pulse tx_start, set USBOE=1 and Encode_Instruction=resp, go to TX.
- TX:
  - USBOE and Encode_Instruction are held. rx_eop/rx_active are ignored (transmit echo).
  - On tx_done: USBOE←0. If resp was DATA0/DATA1, go to WAIT_HS with the counter cleared; otherwise go to IDLE.
- WAIT_HS:
  - The counter increments only while rx_active=0.
  - rx_eop with no error and PID ACK: data_toggle flips; go to IDLE.
  - rx_eop with any other PID or error: go to IDLE, toggle unchanged.
  - count = TIMEOUT_CYCLES−1 with no rx_eop: pulse timeout, go to IDLE, toggle unchanged. The same data is resent on the next IN.
- Simultaneous events:
  - rx_eop together with a counter terminal count in WAIT_HS: rx_eop wins and timeout is not pulsed.
  - tx_done outside TX is ignored.

## Timing
- All outputs are registered.
- Reset values: Encode_Instruction 0000, tx_start 0, USBOE 0, data_toggle 0, timeout 0, busy 0, state IDLE, counter 0.
- Asynchronous reset mid-operation forces USBOE low immediately with no tx_start. Any latched resp is discarded.
- Latency: rx_eop in cycle N gives TURN in N+1, and tx_start plus USBOE rising in cycle N+TURN_CYCLES+1.
- USBOE falls in the cycle after tx_done.
- Encode_Instruction holds its last value in IDLE.
- The counter never wraps: it stops at terminal count. CNT_W-bit unsigned compare.

## Structure
- The shared package usb_pkg holds:
  - the PID localparams above;
  - the state enum typedef (IDLE, TURN, TX, WAIT_HS);
  - a helper function is_data_pid.
- One sub-module, usb_timer: CNT_W-bit counter with clear, enable and a terminal-count output compared against a runtime limit input. It is shared by the TURN and WAIT_HS states.

## Test plan
Defaults for all scenarios: TURN=16, TIMEOUT=144.
- IN with tx_data_ready=1 and toggle 0: tx_start 17 cycles after rx_eop with Encode_Instruction=0011. Then tx_done followed by ACK rx_eop gives data_toggle=1 and busy=0.
- IN with tx_data_ready=0: Encode_Instruction=1010 (NAK). After tx_done, return to IDLE with no WAIT_HS and toggle unchanged.
- DATA1 rx_eop with rx_error=0: ACK (0010) sent. The same packet with rx_error=1: no tx_start and USBOE stays 0.
- DATA sent, no host response: timeout pulses exactly 144 cycles after entering WAIT_HS. The toggle is unchanged and the next IN resends the same DATA PID.
- SETUP sets data_toggle=1, so the following IN sends DATA1 (1011). rx_active asserting during TURN aborts with no tx_start.
- n_rst asserted mid-TX: USBOE=0 and all outputs at reset values within the same cycle. After release, an IN is handled normally.
